// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the Wallace-tree multiplier.
// Everything that depends on WIDTH is a function so each instance sizes its own tree.
package wallace_pkg;

   localparam int STAGES = 3;

`ifdef WALLACE_SIGNED_EN
   localparam int CORR_ROWS = 1;
`else
   localparam int CORR_ROWS = 0;
`endif

   // One 3:2 level turns every full group of three rows into two; leftovers pass through.
   function automatic int rows_next(input int n);
      return n - n / 3;
   endfunction

   function automatic int rows_at(input int n, input int lvl);
      int r;
      r = n;
      for (int i = 0; i < lvl; i++) r = rows_next(r);
      return r;
   endfunction

   // Total 3:2 levels from WIDTH partial products down to two rows; the
   // correction row (signed builds) joins the tree after the first level.
   function automatic int wallace_levels(input int width);
      int r;
      int lv;
      r  = rows_next(width) + CORR_ROWS;
      lv = 1;
      while (r > 2) begin
         r = rows_next(r);
         lv++;
      end
      return lv;
   endfunction

   // Baugh-Wooley constant: 2^W + 2^(2W-1), modulo 2^(2W).
   function automatic logic [63:0] bw_corr(input int width);
      return (64'd1 << (2 * width - 1)) | (64'd1 << width);
   endfunction

endpackage

// File: rtl/wallace_mult_csa_row.sv
// One row of full adders (3:2 compressor) across a W-bit word; carries are
// pre-shifted so both outputs are aligned for the next level.
module csa_row #(
   parameter int W = 16
) (
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   input  logic [W-1:0] z_i,
   output logic [W-1:0] sum_o,
   output logic [W-1:0] carry_o
);

   assign sum_o   = x_i ^ y_i ^ z_i;
   // Top carry falls off: the final product always fits in W bits.
   assign carry_o = {(x_i[W-2:0] & y_i[W-2:0]) | (x_i[W-2:0] & z_i[W-2:0]) |
                     (y_i[W-2:0] & z_i[W-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier: S1 PP matrix + first 3:2 level, S2 remaining
// levels, S3 carry-propagate add, then an output holding register. WALLACE_SIGNED_EN adds signed_mode.
module wallace_mult_pipe
   import wallace_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
`ifdef WALLACE_SIGNED_EN
   input  logic               signed_mode,
`endif
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] prod,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int PW = 2 * WIDTH;
   localparam int N1 = rows_next(WIDTH);
   localparam int R2 = N1 + CORR_ROWS;
   localparam int L2 = wallace_levels(WIDTH) - 1;

   typedef struct packed {
      logic [N1-1:0][PW-1:0] rows;
      logic [TAG_W-1:0]      tag;
`ifdef WALLACE_SIGNED_EN
      logic                  sgn;
`endif
   } s1_t;

   typedef struct packed {
      logic [PW-1:0]    r0;
      logic [PW-1:0]    r1;
      logic [TAG_W-1:0] tag;
   } s2_t;

   typedef struct packed {
      logic [PW-1:0]    prod;
      logic [TAG_W-1:0] tag;
   } res_t;

   // vld_pipe_q[0..2] = S1..S3, vld_pipe_q[STAGES] = output register.
   logic [STAGES:0] vld_pipe_q;
   logic [STAGES:0] adv;
   s1_t             s1_d, s1_q;
   s2_t             s2_d, s2_q;
   res_t            s3_d, s3_q, out_q;

   always_comb begin
      adv[STAGES] = !vld_pipe_q[STAGES] || out_ready;
      for (int k = STAGES - 1; k >= 0; k--) adv[k] = !vld_pipe_q[k] || adv[k+1];
   end

   assign in_ready  = adv[0];
   assign out_valid = vld_pipe_q[STAGES];
   assign prod      = out_q.prod;
   assign out_tag   = out_q.tag;

   logic [PW-1:0] pp [WIDTH];

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         pp[i] = '0;
         for (int j = 0; j < WIDTH; j++) begin
            logic pb;
            pb = a[j] & b[i];
`ifdef WALLACE_SIGNED_EN
            if (signed_mode && ((i == WIDTH - 1) != (j == WIDTH - 1))) pb = ~pb;
`endif
            pp[i][i+j] = pb;
         end
      end
   end

   logic [PW-1:0] l1 [N1];

   for (genvar g = 0; g < WIDTH / 3; g++) begin : g_l1
      csa_row #(.W(PW)) u_csa (
         .x_i    (pp[3*g]),
         .y_i    (pp[3*g+1]),
         .z_i    (pp[3*g+2]),
         .sum_o  (l1[2*g]),
         .carry_o(l1[2*g+1])
      );
   end
   for (genvar k = 0; k < WIDTH % 3; k++) begin : g_l1_pass
      assign l1[2*(WIDTH/3)+k] = pp[3*(WIDTH/3)+k];
   end

   always_comb begin
      s1_d = '0;
      for (int k = 0; k < N1; k++) s1_d.rows[k] = l1[k];
      s1_d.tag = in_tag;
`ifdef WALLACE_SIGNED_EN
      s1_d.sgn = signed_mode;
`endif
   end

   logic [PW-1:0] t0 [R2];

`ifdef WALLACE_SIGNED_EN
   localparam logic [PW-1:0] BW_CORR = PW'(bw_corr(WIDTH));
`endif

   always_comb begin
      for (int k = 0; k < N1; k++) t0[k] = s1_q.rows[k];
`ifdef WALLACE_SIGNED_EN
      t0[R2-1] = s1_q.sgn ? BW_CORR : '0;
`endif
   end

   for (genvar l = 0; l < L2; l++) begin : g_lvl
      localparam int RI = rows_at(R2, l);
      localparam int RO = rows_next(RI);
      logic [PW-1:0] ri [RI];
      logic [PW-1:0] ro [RO];

      for (genvar k = 0; k < RI; k++) begin : g_src
         if (l == 0) begin : g_first
            assign ri[k] = t0[k];
         end else begin : g_next
            assign ri[k] = g_lvl[l-1].ro[k];
         end
      end
      for (genvar g = 0; g < RI / 3; g++) begin : g_csa
         csa_row #(.W(PW)) u_csa (
            .x_i    (ri[3*g]),
            .y_i    (ri[3*g+1]),
            .z_i    (ri[3*g+2]),
            .sum_o  (ro[2*g]),
            .carry_o(ro[2*g+1])
         );
      end
      for (genvar k = 0; k < RI % 3; k++) begin : g_pass
         assign ro[2*(RI/3)+k] = ri[3*(RI/3)+k];
      end
   end

   always_comb begin
      s2_d.r0  = g_lvl[L2-1].ro[0];
      s2_d.r1  = g_lvl[L2-1].ro[1];
      s2_d.tag = s1_q.tag;
   end

   always_comb begin
      s3_d.prod = s2_q.r0 + s2_q.r1;
      s3_d.tag  = s2_q.tag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         s1_q       <= '0;
         s2_q       <= '0;
         s3_q       <= '0;
         out_q      <= '0;
      end else begin
         if (adv[0]) begin
            vld_pipe_q[0] <= in_valid;
            s1_q          <= s1_d;
         end
         if (adv[1]) begin
            vld_pipe_q[1] <= vld_pipe_q[0];
            s2_q          <= s2_d;
         end
         if (adv[2]) begin
            vld_pipe_q[2] <= vld_pipe_q[1];
            s3_q          <= s3_d;
         end
         if (adv[3]) begin
            vld_pipe_q[3] <= vld_pipe_q[2];
            out_q         <= s3_q;
         end
      end
   end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench: 8-bit directed vectors and corner sequences, 16-bit random
// traffic against a queue-based a*b reference.
module tb_wallace_mult_pipe;

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        iv8, ir8, ov8, or8;
   logic [7:0]  a8, b8;
   logic [3:0]  tg8, ot8;
   logic [15:0] p8;

   logic        iv16, ir16, ov16, or16;
   logic [15:0] a16, b16;
   logic [3:0]  tg16, ot16;
   logic [31:0] p16;

`ifdef WALLACE_SIGNED_EN
   logic sm8;
   logic sm16;
`endif

   wallace_mult_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8),
`ifdef WALLACE_SIGNED_EN
      .signed_mode(sm8),
`endif
      .in_ready(ir8), .a(a8), .b(b8), .in_tag(tg8),
      .out_valid(ov8), .out_ready(or8), .prod(p8), .out_tag(ot8)
   );

   wallace_mult_pipe #(.WIDTH(16), .TAG_W(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16),
`ifdef WALLACE_SIGNED_EN
      .signed_mode(sm16),
`endif
      .in_ready(ir16), .a(a16), .b(b16), .in_tag(tg16),
      .out_valid(ov16), .out_ready(or16), .prod(p16), .out_tag(ot16)
   );

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [3:0]  tag;
      logic        sm;
      logic [15:0] exp;
   } vec_t;

   typedef struct { logic [15:0] p; logic [3:0] t; } exp8_t;
   typedef struct { logic [31:0] p; logic [3:0] t; } exp16_t;

   vec_t   vecs[$];
   exp8_t  q8[$];
   exp16_t q16[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic one8(input vec_t v, input int idx);
      int lat;
      a8 = v.a; b8 = v.b; tg8 = v.tag; iv8 = 1'b1;
`ifdef WALLACE_SIGNED_EN
      sm8 = v.sm;
`endif
      chk($sformatf("vec%0d_in_ready", idx), ir8, 1);
      tick();
      iv8 = 1'b0;
      lat = 0;
      while (!ov8 && lat < 10) begin
         tick();
         lat++;
      end
      chk($sformatf("vec%0d_latency", idx), lat, 3);
      chk($sformatf("vec%0d_prod", idx), p8, v.exp);
      chk($sformatf("vec%0d_tag", idx), ot8, v.tag);
      tick();
   endtask

   int          acc, seen, sent, rcvd, cyc;
   logic        stall_prev;
   logic [31:0] pprev;
   logic [3:0]  tprev;
   localparam int NRND = 10000;

   initial begin
      rst_n = 1'b0;
      iv8 = 0; or8 = 1; a8 = 0; b8 = 0; tg8 = 0;
      iv16 = 0; or16 = 1; a16 = 0; b16 = 0; tg16 = 0;
`ifdef WALLACE_SIGNED_EN
      sm8 = 0; sm16 = 0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid8", ov8, 0);
      chk("rst_prod8", p8, 0);
      chk("rst_tag8", ot8, 0);
      chk("rst_out_valid16", ov16, 0);
      chk("rst_prod16", p16, 0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready8", ir8, 1);
      chk("rst_in_ready16", ir16, 1);
      tick();

      vecs.push_back('{8'hFF, 8'hFF, 4'd5, 1'b0, 16'hFE01});
      vecs.push_back('{8'h00, 8'h00, 4'd1, 1'b0, 16'h0000});
      vecs.push_back('{8'd1,  8'd200, 4'd2, 1'b0, 16'd200});
      vecs.push_back('{8'h80, 8'h80, 4'd3, 1'b0, 16'h4000});
      vecs.push_back('{8'hFF, 8'h02, 4'd4, 1'b0, 16'h01FE});
      vecs.push_back('{8'd13, 8'd17, 4'd6, 1'b0, 16'd221});
      vecs.push_back('{8'hAA, 8'h55, 4'd7, 1'b0, 16'h3872});
      vecs.push_back('{8'hFF, 8'h01, 4'd8, 1'b0, 16'h00FF});
      vecs.push_back('{8'h80, 8'hFF, 4'd9, 1'b0, 16'h7F80});
`ifdef WALLACE_SIGNED_EN
      vecs.push_back('{8'h80, 8'h80, 4'hA, 1'b1, 16'h4000});
      vecs.push_back('{8'hFF, 8'h02, 4'hB, 1'b1, 16'hFFFE});
      vecs.push_back('{8'h7F, 8'h80, 4'hC, 1'b1, 16'hC080});
      vecs.push_back('{8'hFF, 8'hFF, 4'hD, 1'b1, 16'h0001});
      vecs.push_back('{8'h80, 8'h7F, 4'hE, 1'b1, 16'hC080});
`endif
      for (int i = 0; i < vecs.size(); i++) one8(vecs[i], i);
`ifdef WALLACE_SIGNED_EN
      sm8 = 1'b0;
`endif

      // Back-to-back stream: one result per cycle, fixed 3-cycle offset.
      or8 = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c < 8) begin
            iv8 = 1'b1; a8 = 8'(c); b8 = 8'(c + 1); tg8 = 4'(c);
         end else iv8 = 1'b0;
         tick();
         if (c >= 3 && c < 11) begin
            chk($sformatf("b2b%0d_valid", c), ov8, 1);
            chk($sformatf("b2b%0d_prod", c), p8, 16'((c - 3) * (c - 2)));
            chk($sformatf("b2b%0d_tag", c), ot8, 4'(c - 3));
         end else chk($sformatf("b2b%0d_idle", c), ov8, 0);
      end

      // Stall: fill all four slots, hold, then drain without loss or duplication.
      or8 = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         a8 = 8'(acc + 3); b8 = 8'(acc * 7 + 5); tg8 = 4'(acc); iv8 = 1'b1;
         if (ir8) begin
            q8.push_back('{16'((acc + 3) * (acc * 7 + 5)), 4'(acc)});
            acc++;
         end
         tick();
      end
      chk("stall_accepts", acc, 4);
      chk("stall_in_ready", ir8, 0);
      for (int c = 0; c < 5; c++) begin
         chk("stall_valid", ov8, 1);
         chk("stall_prod", p8, q8[0].p);
         chk("stall_tag", ot8, q8[0].t);
         chk("stall_in_ready_hold", ir8, 0);
         tick();
      end
      or8 = 1'b1;
      #1;
      chk("unstall_in_ready", ir8, 1);
      q8.push_back('{16'((acc + 3) * (acc * 7 + 5)), 4'(acc)});
      for (int c = 0; c < 15; c++) begin
         if (ov8) begin
            if (q8.size() == 0) chk("stall_no_extra", ov8, 0);
            else begin
               chk("drain_prod", p8, q8[0].p);
               chk("drain_tag", ot8, q8[0].t);
               void'(q8.pop_front());
            end
         end
         tick();
         if (c == 0) iv8 = 1'b0;
      end
      chk("drain_left", q8.size(), 0);

      // Mid-operation reset with one result showing and two in flight.
      for (int i = 0; i < 3; i++) begin
         a8 = 8'(i + 9); b8 = 8'(i + 20); tg8 = 4'(i + 1); iv8 = 1'b1;
         tick();
      end
      iv8 = 1'b0;
      tick();
      chk("prereset_valid", ov8, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", ov8, 0);
      chk("midrst_prod", p8, 0);
      chk("midrst_tag", ot8, 0);
      tick();
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (ov8) seen++;
      end
      chk("postrst_quiet", seen, 0);

      // 16-bit random traffic with random back-pressure.
      sent = 0; rcvd = 0; cyc = 0; stall_prev = 1'b0; pprev = '0; tprev = '0;
      while (rcvd < NRND && cyc < 60000) begin
         if (sent < NRND) begin
            iv16 = ($urandom_range(0, 9) != 0);
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            tg16 = 4'($urandom);
         end else iv16 = 1'b0;
         or16 = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (stall_prev) begin
            chk("rnd_hold_valid", ov16, 1);
            chk("rnd_hold_prod", p16, pprev);
            chk("rnd_hold_tag", ot16, tprev);
         end
         if (iv16 && ir16) begin
            q16.push_back('{32'(a16) * 32'(b16), tg16});
            sent++;
         end
         if (ov16 && or16) begin
            if (q16.size() == 0) chk("rnd_spurious", ov16, 0);
            else begin
               chk("rnd_prod", p16, q16[0].p);
               chk("rnd_tag", ot16, q16[0].t);
               void'(q16.pop_front());
            end
            rcvd++;
         end
         stall_prev = ov16 && !or16;
         pprev = p16;
         tprev = ot16;
         tick();
         cyc++;
      end
      chk("rnd_count", rcvd, NRND);
      chk("rnd_left", q16.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wallace_mult_pipe.md
WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values 4..32.
REQ-002 SHALL have parameter TAG_W, default 4, width of the transaction tag passed alongside the operands.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, operands and tag present.
REQ-006 SHALL have port in_ready, output, 1, block accepts the operands this cycle.
REQ-007 SHALL have port a, input, WIDTH, multiplicand.
REQ-008 SHALL have port b, input, WIDTH, multiplier.
REQ-009 SHALL have port in_tag, input, TAG_W, opaque transaction tag.
REQ-010 SHALL have port out_valid, output, 1, product present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the product.
REQ-012 SHALL have port prod, output, 2*WIDTH, full product.
REQ-013 SHALL have port out_tag, output, TAG_W, tag of the transaction in prod.

Function
REQ-014 SHALL implement a 3-stage pipeline: S1 partial-product AND matrix plus first Wallace 3:2 level; S2 remaining 3:2 levels down to two rows; S3 final carry-propagate add into prod.
REQ-015 SHALL register the output of every stage together with a per-stage valid bit and the tag.
REQ-016 SHALL give a latency of exactly 3 cycles from an accepted input (in_valid && in_ready at edge N) to out_valid high after edge N+3, when out_ready stays high.
REQ-017 SHALL sustain one product per cycle when out_ready is held high.
REQ-018 SHALL advance stage k when its register is empty or stage k+1 advances this cycle; stage 3 advances when out_valid is low or out_ready is high.
REQ-019 SHALL drive in_ready combinationally as the stage-1 advance condition; an input offered with in_ready low is not consumed.
REQ-020 SHALL collapse bubbles: an empty stage is filled even while the output is stalled.
REQ-021 SHALL hold prod, out_tag and out_valid stable while out_valid is high and out_ready is low.
REQ-022 SHALL deliver products in acceptance order; out_tag always equals the in_tag of the same transaction.
REQ-023 SHALL, when a stage advances with no valid input behind it, clear the next stage's valid bit; datapath contents of invalid stages are don't-care.
REQ-024 SHALL produce an exact product: no truncation or rounding, and no overflow is possible in 2*WIDTH bits.

Reset
REQ-025 SHALL, while rst_n is low, clear all stage valid bits, so out_valid=0 and in_ready=1 after reset release.
REQ-026 SHALL reset prod and out_tag to 0.
REQ-027 SHALL discard all in-flight transactions on a mid-operation reset; none emerge after rst_n rises.

Configuration
REQ-028 SHALL, with macro WALLACE_SIGNED_EN defined, add input port signed_mode (1 bit, sampled with a), treat a and b as two's complement when it is 1 using Baugh-Wooley partial-product inversion and correction constants, and carry the mode bit through the pipeline per transaction.
REQ-029 SHALL, without WALLACE_SIGNED_EN, omit signed_mode and treat all operands as unsigned.

Structure
REQ-030 SHALL place the stage-count constant (3), the Wallace level-count function of WIDTH and the Baugh-Wooley correction-constant function in shared package wallace_pkg.
REQ-031 SHALL use one sub-module, csa_row, a parametrised row of full/half adders (3:2 compressor) instantiated for each reduction level.

Verification
REQ-032 WIDTH=8, a=255, b=255, out_ready=1 -> prod=16'hFE01 with out_valid exactly 3 cycles after acceptance.
REQ-033 WIDTH=8, 8 back-to-back inputs (a=i, b=i+1, tag=i, i=0..7), out_ready=1 -> 8 consecutive out_valid cycles, prod=i*(i+1), out_tag=i in order.
REQ-034 Fill the pipeline, then hold out_ready=0 for 5 cycles -> in_ready=0 once 3 stages plus the output are full, prod/out_tag frozen, no loss or duplication after out_ready returns to 1.
REQ-035 WALLACE_SIGNED_EN, signed_mode=1: a=8'h80, b=8'h80 -> prod=16'h4000; a=8'hFF, b=8'h02 -> prod=16'hFFFE; the same operands with signed_mode=0 -> 16'h4000 and 16'h01FE.
REQ-036 Assert rst_n low with 2 transactions in flight -> out_valid=0 and prod=0 immediately; no output after release until a new input is accepted.
REQ-037 WIDTH=16 random unsigned operands (10k), random out_ready -> every prod equals the reference a*b, in order.
